// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall, BEQ flush and memory-wait freeze sequencing for the 5-stage RV32 pipe
// Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] id_opcode_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_branch_taken_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ack_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_bubble_o,
    output logic       pipe_hold_o,
    output logic       timeout_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TMO      = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             use_rs1, use_rs2;
    logic             load_use;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opcode_i)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((use_rs1 && (id_rs1_i == ex_rd_i)) ||
                       (use_rs2 && (id_rs2_i == ex_rd_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        timeout_o     = 1'b0;
        case (state)
            RUN: begin
                // Freeze starts in the issue cycle so nothing advances past the stalled access.
                if (dmem_req_i && !dmem_ack_i) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = TMO_W'(1);
                    pipe_hold_o  = 1'b1;
                end else if (load_use) begin
                    idex_bubble_o = 1'b1;
                end else begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    ifid_flush_o = id_branch_taken_i;
                end
            end
            MEM_WAIT: begin
                pipe_hold_o = 1'b1;
                if (dmem_ack_i) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TMO_W'(TMO_MAX)) begin
                    state_nxt = TMO;
                end else begin
                    wait_cnt_nxt = wait_cnt + TMO_W'(1);
                end
            end
            TMO: begin
                pipe_hold_o = 1'b1;
                timeout_o   = 1'b1;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
        if (!rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b0;
            pipe_hold_o   = 1'b0;
            timeout_o     = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_stall_o <= '0;
            perf_flush_o <= '0;
        end else begin
            if (!pc_write_o && (perf_stall_o != 32'hFFFF_FFFF))
                perf_stall_o <= perf_stall_o + 32'd1;
            if (ifid_flush_o && (perf_flush_o != 32'hFFFF_FFFF))
                perf_flush_o <= perf_flush_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed and randomized checks of hazard_stall_ctrl against a behavioural model
module tb_hazard_stall_ctrl;

    localparam int TMO_W   = 8;
    localparam int TMO_MAX = 200;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [6:0] id_opcode_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic       id_branch_taken_i, ex_memread_i, dmem_req_i, dmem_ack_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, timeout_o;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_o, perf_flush_o;
`endif

    hazard_stall_ctrl #(.TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .id_opcode_i       (id_opcode_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_branch_taken_i (id_branch_taken_i),
        .ex_memread_i      (ex_memread_i),
        .ex_rd_i           (ex_rd_i),
        .dmem_req_i        (dmem_req_i),
        .dmem_ack_i        (dmem_ack_i),
        .pc_write_o        (pc_write_o),
        .ifid_write_o      (ifid_write_o),
        .ifid_flush_o      (ifid_flush_o),
        .idex_bubble_o     (idex_bubble_o),
        .pipe_hold_o       (pipe_hold_o),
        .timeout_o         (timeout_o)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall_o      (perf_stall_o),
        .perf_flush_o      (perf_flush_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a memory access is either idle, pending for some number of cycles, or timed out.
    bit  m_pending, m_tmo;
    int  m_age;
    longint m_stalls, m_flushes;

    function automatic logic [1:0] operands_used(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011: return 2'b11;
            7'b0010011, 7'b0000011:             return 2'b01;
            default:                            return 2'b00;
        endcase
    endfunction

    // Expected {pc_write, ifid_write, flush, bubble, hold, timeout}
    function automatic logic [5:0] expected_outs();
        logic [1:0] u;
        logic       lu;
        u  = operands_used(id_opcode_i);
        lu = ex_memread_i && ex_rd_i != 0 &&
             ((u[0] && id_rs1_i == ex_rd_i) || (u[1] && id_rs2_i == ex_rd_i));
        if (!rst_i)                               return 6'b000000;
        if (m_tmo)                                return 6'b000011;
        if (m_pending || (dmem_req_i && !dmem_ack_i)) return 6'b000010;
        if (lu)                                   return 6'b000100;
        if (id_branch_taken_i)                    return 6'b111000;
        return 6'b110000;
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_pending = 0; m_tmo = 0; m_age = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            logic [5:0] e;
            e = expected_outs();
            if (!e[5]) m_stalls = (m_stalls < 64'hFFFFFFFF) ? m_stalls + 1 : m_stalls;
            if (e[3])  m_flushes = (m_flushes < 64'hFFFFFFFF) ? m_flushes + 1 : m_flushes;
            if (m_tmo) begin
            end else if (m_pending) begin
                if (dmem_ack_i)            m_pending = 0;
                else if (m_age == TMO_MAX) m_tmo = 1;
                else                       m_age++;
            end else if (dmem_req_i && !dmem_ack_i) begin
                m_pending = 1;
                m_age     = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("outs", {26'd0, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
                       pipe_hold_o, timeout_o}, {26'd0, expected_outs()});
`ifdef HAZ_PERF_CNT_EN
        check("perf_stall", perf_stall_o, m_stalls[31:0]);
        check("perf_flush", perf_flush_o, m_flushes[31:0]);
`endif
    end

    logic [5:0] s;
    task automatic step();
        @(negedge clk);
        s = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, timeout_o};
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_opcode_i = 7'b0110011; id_rs1_i = 0; id_rs2_i = 0; id_branch_taken_i = 0;
        ex_memread_i = 0; ex_rd_i = 0; dmem_req_i = 0; dmem_ack_i = 0;
    endtask

    logic [6:0] ops [8];
    int holds, first_tmo;

    initial begin
        ops[0] = 7'b0110011; ops[1] = 7'b0100011; ops[2] = 7'b1100011; ops[3] = 7'b0010011;
        ops[4] = 7'b0000011; ops[5] = 7'b1101111; ops[6] = 7'b0110111; ops[7] = 7'b0000000;
        rst_i = 0;
        idle_inputs();
        repeat (3) begin
            step();
            check("reset_outs", {26'd0, s}, 32'h0);
        end
        rst_i = 1;
        step();
        check("after_reset", {26'd0, s}, {26'd0, 6'b110000});

        // load-use on rs2 of an R-type
        ex_memread_i = 1; ex_rd_i = 5; id_opcode_i = 7'b0110011; id_rs1_i = 1; id_rs2_i = 5;
        step();
        check("lu_stall", {26'd0, s}, {26'd0, 6'b000100});
        ex_memread_i = 0;
        step();
        check("lu_one_cycle", {26'd0, s}, {26'd0, 6'b110000});
        ex_memread_i = 1; ex_rd_i = 0; id_rs2_i = 0;
        step();
        check("lu_x0", {26'd0, s}, {26'd0, 6'b110000});

        // I-type ignores rs2
        ex_rd_i = 5; id_opcode_i = 7'b0010011; id_rs1_i = 3; id_rs2_i = 5;
        step();
        check("itype_rs2", {26'd0, s}, {26'd0, 6'b110000});
        id_rs1_i = 5;
        step();
        check("itype_rs1", {26'd0, s}, {26'd0, 6'b000100});

        // branch flush, then branch behind a load-use
        idle_inputs();
        id_opcode_i = 7'b1100011; id_branch_taken_i = 1;
        step();
        check("br_flush", {26'd0, s}, {26'd0, 6'b111000});
        id_branch_taken_i = 0;
        step();
        check("br_once", {26'd0, s}, {26'd0, 6'b110000});
        id_branch_taken_i = 1; ex_memread_i = 1; ex_rd_i = 7; id_rs1_i = 7;
        step();
        check("br_lu_stall", {26'd0, s}, {26'd0, 6'b000100});
        ex_memread_i = 0;
        step();
        check("br_lu_flush", {26'd0, s}, {26'd0, 6'b111000});

        // memory wait acked on the 4th wait cycle
        idle_inputs();
        dmem_req_i = 1; dmem_ack_i = 1;
        step();
        check("req_acked_same", {26'd0, s}, {26'd0, 6'b110000});
        holds = 0;
        dmem_ack_i = 0;
        step(); if (s[1]) holds++;
        dmem_req_i = 0;
        repeat (3) begin step(); if (s[1]) holds++; end
        dmem_ack_i = 1;
        step(); if (s[1]) holds++;
        dmem_ack_i = 0;
        step();
        check("mem_hold_cycles", holds, 5);
        check("mem_back_run", {26'd0, s}, {26'd0, 6'b110000});

        // timeout
        dmem_req_i = 1; first_tmo = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            dmem_req_i = 0;
            if (s[0] && first_tmo < 0) first_tmo = i;
            if (first_tmo >= 0 && i > first_tmo + 3) break;
        end
        check("tmo_cycle", first_tmo, TMO_MAX + 1);
        dmem_ack_i = 1;
        step();
        check("tmo_sticky", {26'd0, s}, {26'd0, 6'b000011});
        rst_i = 0;
        step();
        check("tmo_reset", {26'd0, s}, 32'h0);
        rst_i = 1; dmem_ack_i = 0;
        step();
        check("tmo_cleared", {26'd0, s}, {26'd0, 6'b110000});

        // randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            if (!rst_i) rst_i = ($urandom_range(1, 0) == 1);
            else if ($urandom_range(199, 0) == 0) rst_i = 0;
            id_opcode_i       = ops[$urandom_range(7, 0)];
            id_rs1_i          = 5'($urandom_range(3, 0));
            id_rs2_i          = 5'($urandom_range(3, 0));
            ex_rd_i           = 5'($urandom_range(3, 0));
            ex_memread_i      = ($urandom_range(2, 0) == 0);
            id_branch_taken_i = ($urandom_range(3, 0) == 0);
            dmem_req_i        = ($urandom_range(6, 0) == 0);
            dmem_ack_i        = ($urandom_range(3, 0) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
